// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg -- shared definitions for the mc_cpu multi-cycle core.
//
// Contents:
//   - instruction width, register count and instruction field positions
//   - instr_t: packed view of a 16-bit instruction word
//   - opcode constants OP_NOP..OP_HALT
//   - branch-condition codes carried in the rd field of BR
//   - FSM state encoding
//   - is_alu_op(): true for the opcodes that go through the ALU and update flags
package mc_cpu_pkg;

  localparam int INSTR_W  = 16;
  localparam int NUM_REGS = 4;

  // Instruction field positions: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [OP_MSB-OP_LSB:0]   op;
    logic [RD_MSB-RD_LSB:0]   rd;
    logic [RS_MSB-RS_LSB:0]   rs;
    logic [IMM_MSB-IMM_LSB:0] imm;
  } instr_t;

  // Opcodes
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_IN   = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_BR   = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Branch conditions (rd field of a BR instruction)
  localparam logic [1:0] BR_ALWAYS = 2'd0;
  localparam logic [1:0] BR_Z      = 2'd1;
  localparam logic [1:0] BR_N      = 2'd2;
  localparam logic [1:0] BR_CALL   = 2'd3;

  // FSM states
  localparam logic [2:0] ST_FETCH    = 3'd0;
  localparam logic [2:0] ST_EXEC     = 3'd1;
  localparam logic [2:0] ST_MEM      = 3'd2;
  localparam logic [2:0] ST_IN_WAIT  = 3'd3;
  localparam logic [2:0] ST_OUT_WAIT = 3'd4;
  localparam logic [2:0] ST_HALT     = 3'd5;

  // ALU-class opcodes are the only ones that write the N/Z flags
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/mc_alu.sv
// mc_alu -- combinational ALU for the mc_cpu core.
//
// Ports:
//   op     in  4       opcode (only OP_ADD..OP_SHR produce a result; others give 0)
//   a      in  DATA_W  first operand (rd)
//   b      in  DATA_W  second operand (rs); ignored by the shifts
//   result out DATA_W  result, modulo 2^DATA_W
//   z      out 1       result == 0
//   n      out 1       result MSB
module mc_alu
  import mc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n
);

  // Carry out of ADD/SUB is deliberately dropped: the ISA has no carry flag.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = {a[DATA_W-2:0], 1'b0};
      OP_SHR:  result = {1'b0, a[DATA_W-1:1]};
      default: result = '0;
    endcase
  end

  assign z = (result == '0);
  assign n = result[DATA_W-1];

endmodule

// File: rtl/mc_cpu.sv
// mc_cpu -- parametrised multi-cycle CPU core with four registers, a
// synchronous data memory and valid/ready handshaked input/output ports.
//
// Parameters:
//   DATA_W      register / ALU / memory / port width (8..32)
//   DMEM_DEPTH  data-memory words (2..256); address is the low bits of imm
//   PC_W        program-counter width; pc wraps modulo 2^PC_W
//
// Ports:
//   clk           in  1       clock, rising edge
//   rst_n         in  1       asynchronous active-low reset
//   imem_addr     out PC_W    instruction address (= pc)
//   imem_data     in  16      instruction word, sampled at the end of FETCH
//   in_data       in  DATA_W  input-port data
//   in_valid      in  1       in_data valid
//   in_ready      out 1       core waiting in IN_WAIT
//   out_data      out DATA_W  output-port data, stable while out_valid=1
//   out_valid     out 1       core waiting in OUT_WAIT
//   out_ready     in  1       consumer accepts out_data
//   halted        out 1       core is in HALT
//   flags         out 2       {N, Z}
//
// Optional build macro MC_CPU_PERF_EN adds:
//   retired       out 32      completed-instruction count (HALT counts once)
//   stall_cycles  out 32      IN_WAIT / OUT_WAIT cycles without a handshake
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DMEM_DEPTH = 256,
  parameter int PC_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               halted,
  output logic [1:0]         flags
`ifdef MC_CPU_PERF_EN
  ,
  output logic [31:0]        retired,
  output logic [31:0]        stall_cycles
`endif
);

  localparam int DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [2:0]          state;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     lr;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     br_target;
  logic [INSTR_W-1:0]  ir;
  instr_t              ins;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   dmem [DMEM_DEPTH];
  logic [DATA_W-1:0]   mem_rdata;
  logic [DATA_W-1:0]   out_data_q;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   alu_result;
  logic [DMEM_AW-1:0]  dmem_addr;
  logic                flag_z;
  logic                flag_n;
  logic                alu_z;
  logic                alu_n;
  logic                br_taken;

  assign ins       = instr_t'(ir);
  assign imm_ext   = DATA_W'(ins.imm);
  // Upper imm bits are ignored when the memory is smaller than 256 words.
  assign dmem_addr = ins.imm[DMEM_AW-1:0];
  assign pc_inc    = pc + PC_W'(1);
  assign br_target = PC_W'(ins.imm);

  mc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (ins.op),
    .a      (regs[ins.rd]),
    .b      (regs[ins.rs]),
    .result (alu_result),
    .z      (alu_z),
    .n      (alu_n)
  );

  // Branch condition uses the registered flags, never the ALU outputs.
  always_comb begin
    br_taken = 1'b0;
    case (ins.rd)
      BR_ALWAYS: br_taken = 1'b1;
      BR_Z:      br_taken = flag_z;
      BR_N:      br_taken = flag_n;
      BR_CALL:   br_taken = 1'b1;
      default:   br_taken = 1'b0;
    endcase
  end

  // Data memory has no reset so its contents survive a core reset.
  always_ff @(posedge clk) begin
    if (state == ST_EXEC && ins.op == OP_ST) begin
      dmem[dmem_addr] <= regs[ins.rd];
    end
    if (state == ST_EXEC && ins.op == OP_LD) begin
      mem_rdata <= dmem[dmem_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      pc         <= '0;
      lr         <= '0;
      ir         <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      out_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          ir    <= imem_data;
          state <= ST_EXEC;
        end

        ST_EXEC: begin
          if (is_alu_op(ins.op)) begin
            regs[ins.rd] <= alu_result;
            flag_z       <= alu_z;
            flag_n       <= alu_n;
            pc           <= pc_inc;
            state        <= ST_FETCH;
          end else begin
            case (ins.op)
              OP_LDI: begin
                regs[ins.rd] <= imm_ext;
                pc           <= pc_inc;
                state        <= ST_FETCH;
              end
              OP_LD: begin
                state <= ST_MEM;
              end
              OP_IN: begin
                state <= ST_IN_WAIT;
              end
              // out_data is captured here and then frozen for the whole wait.
              OP_OUT: begin
                out_data_q <= regs[ins.rd];
                state      <= ST_OUT_WAIT;
              end
              OP_BR: begin
                pc <= br_taken ? br_target : pc_inc;
                if (ins.rd == BR_CALL) begin
                  lr <= pc_inc;
                end
                state <= ST_FETCH;
              end
              OP_RET: begin
                pc    <= lr;
                state <= ST_FETCH;
              end
              OP_HALT: begin
                state <= ST_HALT;
              end
              // NOP and ST (the memory write is in the data-memory block)
              default: begin
                pc    <= pc_inc;
                state <= ST_FETCH;
              end
            endcase
          end
        end

        ST_MEM: begin
          regs[ins.rd] <= mem_rdata;
          pc           <= pc_inc;
          state        <= ST_FETCH;
        end

        ST_IN_WAIT: begin
          if (in_valid) begin
            regs[ins.rd] <= in_data;
            pc           <= pc_inc;
            state        <= ST_FETCH;
          end
        end

        ST_OUT_WAIT: begin
          if (out_ready) begin
            pc    <= pc_inc;
            state <= ST_FETCH;
          end
        end

        ST_HALT: begin
          state <= ST_HALT;
        end

        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  // Handshake outputs are pure state decode so neither side can form a
  // combinational loop through the partner's valid/ready.
  assign in_ready  = (state == ST_IN_WAIT);
  assign out_valid = (state == ST_OUT_WAIT);
  assign halted    = (state == ST_HALT);
  assign out_data  = out_data_q;
  assign imem_addr = pc;
  assign flags     = {flag_n, flag_z};

`ifdef MC_CPU_PERF_EN
  logic retire_evt;
  logic stall_evt;

  // An EXEC that does not go on to MEM/IN_WAIT/OUT_WAIT either returns to
  // FETCH or enters HALT; both count as one retirement.
  assign retire_evt = ((state == ST_EXEC) && (ins.op != OP_LD) &&
                       (ins.op != OP_IN) && (ins.op != OP_OUT)) ||
                      (state == ST_MEM) ||
                      ((state == ST_IN_WAIT) && in_valid) ||
                      ((state == ST_OUT_WAIT) && out_ready);

  assign stall_evt  = ((state == ST_IN_WAIT) && !in_valid) ||
                      ((state == ST_OUT_WAIT) && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      if (retire_evt) begin
        retired <= retired + 32'd1;
      end
      if (stall_evt) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu -- self-checking bench for mc_cpu.
// Runs an 8-bit core (main tests) and a 16-bit core with a 16-word data
// memory (width sweep and address aliasing). Programs live in bench-side
// instruction arrays; expected values come from hand tables and from a
// small instruction-level model.
module tb_mc_cpu;

  // Opcodes as the bench understands the ISA
  localparam logic [3:0] T_NOP = 4'h0, T_ADD = 4'h1, T_SUB = 4'h2, T_AND = 4'h3;
  localparam logic [3:0] T_OR  = 4'h4, T_XOR = 4'h5, T_SHL = 4'h6, T_SHR = 4'h7;
  localparam logic [3:0] T_LDI = 4'h8, T_LD  = 4'h9, T_ST  = 4'hA, T_IN  = 4'hB;
  localparam logic [3:0] T_OUT = 4'hC, T_BR  = 4'hD, T_RET = 4'hE, T_HALT = 4'hF;
  localparam logic [15:0] HALT_W = 16'hF000;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       n;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        halted;
  logic [1:0]  flags;

  logic [7:0]  imem_addr16;
  logic [15:0] imem_data16;
  logic [15:0] in_data16 = '0;
  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] out_data16;
  logic        out_valid16;
  logic        out_ready16 = 1'b0;
  logic        halted16;
  logic [1:0]  flags16;

`ifdef MC_CPU_PERF_EN
  logic [31:0] retired, stall_cycles, retired16, stall_cycles16;
`endif

  logic [15:0] imem   [256];
  logic [15:0] imem16 [256];

  assign imem_data   = imem[imem_addr];
  assign imem_data16 = imem16[imem_addr16];

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [10];

  always #5 clk = ~clk;

  mc_cpu #(.DATA_W(8), .DMEM_DEPTH(256), .PC_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted),
    .flags     (flags)
`ifdef MC_CPU_PERF_EN
    ,
    .retired      (retired),
    .stall_cycles (stall_cycles)
`endif
  );

  mc_cpu #(.DATA_W(16), .DMEM_DEPTH(16), .PC_W(8)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_addr (imem_addr16),
    .imem_data (imem_data16),
    .in_data   (in_data16),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .out_data  (out_data16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .halted    (halted16),
    .flags     (flags16)
`ifdef MC_CPU_PERF_EN
    ,
    .retired      (retired16),
    .stall_cycles (stall_cycles16)
`endif
  );

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Instruction-level reference for 8-bit ALU ops, in plain integer arithmetic
  function automatic int model_alu(input int op, input int a, input int b);
    case (op)
      1: return (a + b) % 256;
      2: return (a - b + 256) % 256;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return (a * 2) % 256;
      7: return a / 2;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) begin
      imem[i]   = HALT_W;
      imem16[i] = HALT_W;
    end
  endtask

  task automatic reset_core();
    @(negedge clk);
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    out_ready16 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input string name, input logic [7:0] target, output int cycles);
    cycles = 0;
    while (imem_addr != target && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput(name, imem_addr, target);
  endtask

  task automatic wait_halt(input string name);
    int c;
    c = 0;
    while (!halted && c < 20) begin
      @(negedge clk);
      c++;
    end
    checkOutput(name, halted, 1);
  endtask

  // Waits for out_valid, records data/flags, holds out_ready low for `delay`
  // further cycles while watching out_data, then completes the handshake.
  task automatic wait_out(input int delay, output logic [7:0] data, output logic [1:0] flg,
                          output int cycles, output bit stable, output bit seen);
    cycles = 0;
    stable = 1'b1;
    seen   = 1'b0;
    data   = '0;
    flg    = '0;
    while (!out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    if (out_valid) begin
      seen = 1'b1;
      data = out_data;
      flg  = flags;
      repeat (delay) begin
        @(negedge clk);
        if (!out_valid || out_data !== data) stable = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic wait_out16(output logic [15:0] data, output bit seen);
    int c;
    c    = 0;
    seen = 1'b0;
    data = '0;
    while (!out_valid16 && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (out_valid16) begin
      seen = 1'b1;
      data = out_data16;
      out_ready16 = 1'b1;
      @(negedge clk);
      out_ready16 = 1'b0;
    end
  endtask

  // One table vector: LDI R0,a; LDI R1,b; op R0,R1; OUT R0; HALT
  task automatic applyStimulus(input vec_t v, output logic [7:0] got, output logic [1:0] flg,
                               output int cycles, output bit seen);
    bit stable;
    clear_imem();
    imem[0] = enc(T_LDI, 2'd0, 2'd0, v.a);
    imem[1] = enc(T_LDI, 2'd1, 2'd0, v.b);
    imem[2] = enc(v.op, 2'd0, 2'd1, 8'h00);
    imem[3] = enc(T_OUT, 2'd0, 2'd0, 8'h00);
    imem[4] = HALT_W;
    reset_core();
    wait_out(0, got, flg, cycles, stable, seen);
  endtask

  logic [7:0]  got8;
  logic [1:0]  got_flags;
  logic [15:0] got16;
  int          cyc;
  int          hi;
  bit          seen;
  bit          stable;
  bit          done;
  int          m [4];
  logic        mz, mn;
  logic [3:0]  rop;
  logic [1:0]  rrd, rrs;
  int          rv;
  int          exp16;

  initial begin
    vecs[0] = '{T_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{T_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1};
    vecs[2] = '{T_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[3] = '{T_OR,  8'h80, 8'h01, 8'h81, 1'b0, 1'b1};
    vecs[4] = '{T_XOR, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{T_SHL, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0};
    vecs[6] = '{T_SHR, 8'h81, 8'h00, 8'h40, 1'b0, 1'b0};
    vecs[7] = '{T_SHL, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{T_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{T_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};

    clear_imem();

    // Reset state
    @(negedge clk);
    checkOutput("reset_pc", imem_addr, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_halted", halted, 0);
    checkOutput("reset_flags", flags, 0);
    checkOutput("reset_out_data", out_data, 0);

    // Table-driven ALU vectors
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], got8, got_flags, cyc, seen);
      checkOutput("vec_out_seen", seen, 1);
      checkOutput("vec_result", got8, vecs[i].res);
      checkOutput("vec_flags", got_flags, {vecs[i].n, vecs[i].z});
      checkOutput("vec_latency", cyc, 8);
      wait_halt("vec_halted");
    end

    // Reset in the middle of an OUT stall
    clear_imem();
    imem[0] = enc(T_LDI, 2'd1, 2'd0, 8'h5A);
    imem[1] = enc(T_OUT, 2'd1, 2'd0, 8'h00);
    reset_core();
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("rst_mid_out_valid_seen", out_valid, 1);
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_data !== 8'h5A) stable = 1'b0;
    end
    checkOutput("rst_mid_out_data_hold", stable, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid_drop", out_valid, 0);
    checkOutput("rst_mid_pc", imem_addr, 0);
    checkOutput("rst_mid_out_data", out_data, 0);
    imem[0] = enc(T_OUT, 2'd1, 2'd0, 8'h00);
    imem[1] = HALT_W;
    @(negedge clk);
    rst_n = 1'b1;
    wait_out(0, got8, got_flags, cyc, stable, seen);
    checkOutput("rst_r1_seen", seen, 1);
    checkOutput("rst_r1_cleared", got8, 0);

    // Memory round trip
    clear_imem();
    imem[0] = enc(T_LDI, 2'd2, 2'd0, 8'h33);
    imem[1] = enc(T_ST,  2'd2, 2'd0, 8'h10);
    imem[2] = enc(T_LD,  2'd3, 2'd0, 8'h10);
    imem[3] = enc(T_OUT, 2'd3, 2'd0, 8'h00);
    reset_core();
    wait_pc("mem_ldi_pc", 8'd1, cyc);
    wait_pc("mem_st_pc", 8'd2, cyc);
    checkOutput("mem_st_cycles", cyc, 2);
    wait_pc("mem_ld_pc", 8'd3, cyc);
    checkOutput("mem_ld_cycles", cyc, 3);
    wait_out(0, got8, got_flags, cyc, stable, seen);
    checkOutput("mem_out_seen", seen, 1);
    checkOutput("mem_round_trip", got8, 8'h33);

    // IN with a late producer, then OUT with a late consumer
    clear_imem();
    imem[0] = enc(T_IN,  2'd0, 2'd0, 8'h00);
    imem[1] = enc(T_OUT, 2'd0, 2'd0, 8'h00);
    reset_core();
    hi   = 0;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        hi++;
        if (hi == 5) begin
          in_valid = 1'b1;
          in_data  = 8'h7E;
        end
      end else if (hi > 0) begin
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    checkOutput("in_ready_cycles", hi, 5);
    checkOutput("in_pc_after", imem_addr, 1);
    wait_out(2, got8, got_flags, cyc, stable, seen);
    checkOutput("out_seen", seen, 1);
    checkOutput("out_data_value", got8, 8'h7E);
    checkOutput("out_data_stable", stable, 1);

    // Branch, call, return and halt
    clear_imem();
    imem[8'h00] = enc(T_LDI, 2'd0, 2'd0, 8'h01);
    imem[8'h01] = enc(T_ADD, 2'd0, 2'd0, 8'h00);
    imem[8'h02] = enc(T_BR,  2'd3, 2'd0, 8'h20);
    imem[8'h20] = enc(T_RET, 2'd0, 2'd0, 8'h00);
    imem[8'h03] = enc(T_BR,  2'd1, 2'd0, 8'h30);
    imem[8'h04] = enc(T_SUB, 2'd0, 2'd0, 8'h00);
    imem[8'h05] = enc(T_BR,  2'd1, 2'd0, 8'h40);
    imem[8'h40] = enc(T_BR,  2'd2, 2'd0, 8'h50);
    imem[8'h41] = enc(T_BR,  2'd0, 2'd0, 8'h60);
    imem[8'h60] = enc(T_NOP, 2'd0, 2'd0, 8'h00);
    reset_core();
    wait_pc("br_setup_pc", 8'h02, cyc);
    wait_pc("call_target", 8'h20, cyc);
    checkOutput("call_cycles", cyc, 2);
    wait_pc("ret_to_link", 8'h03, cyc);
    checkOutput("ret_cycles", cyc, 2);
    wait_pc("br_z_untaken", 8'h04, cyc);
    checkOutput("br_z_untaken_cycles", cyc, 2);
    wait_pc("br_setup_z", 8'h05, cyc);
    wait_pc("br_z_taken", 8'h40, cyc);
    wait_pc("br_n_untaken", 8'h41, cyc);
    wait_pc("br_always", 8'h60, cyc);
    wait_pc("nop_advance", 8'h61, cyc);
    wait_halt("halt_reached");
    repeat (5) @(negedge clk);
    checkOutput("halt_pc_frozen", imem_addr, 8'h61);
    checkOutput("halt_still", halted, 1);

    // 16-bit core: shift sweep and data-memory aliasing (16 words)
    clear_imem();
    imem16[0] = enc(T_LDI, 2'd0, 2'd0, 8'hFF);
    for (int k = 1; k <= 9; k++) imem16[k] = enc(T_SHL, 2'd0, 2'd0, 8'h00);
    imem16[10] = enc(T_OUT, 2'd0, 2'd0, 8'h00);
    imem16[11] = enc(T_ST,  2'd0, 2'd0, 8'h13);
    imem16[12] = enc(T_LD,  2'd1, 2'd0, 8'h03);
    imem16[13] = enc(T_OUT, 2'd1, 2'd0, 8'h00);
    reset_core();
    for (int k = 1; k <= 9; k++) begin
      cyc = 0;
      while (imem_addr16 != 8'(k + 1) && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      exp16 = (255 << k) % 65536;
      checkOutput("shl16_pc", imem_addr16, k + 1);
      checkOutput("shl16_flags", flags16, {exp16 >= 32768, exp16 == 0});
    end
    wait_out16(got16, seen);
    checkOutput("w16_out_seen", seen, 1);
    checkOutput("w16_result", got16, 16'hFE00);
    wait_out16(got16, seen);
    checkOutput("w16_alias_seen", seen, 1);
    checkOutput("w16_alias_ld", got16, 16'hFE00);

    // Randomized ALU programs against the instruction-level model
    for (int iter = 0; iter < 20; iter++) begin
      clear_imem();
      for (int r = 0; r < 4; r++) begin
        rv = int'($urandom_range(0, 255));
        m[r] = rv;
        imem[r] = enc(T_LDI, 2'(r), 2'd0, 8'(rv));
      end
      mz = 1'b0;
      mn = 1'b0;
      for (int k = 0; k < 6; k++) begin
        rop = 4'($urandom_range(1, 7));
        rrd = 2'($urandom_range(0, 3));
        rrs = 2'($urandom_range(0, 3));
        imem[4 + k] = enc(rop, rrd, rrs, 8'h00);
        rv = model_alu(int'(rop), m[rrd], m[rrs]);
        m[rrd] = rv;
        mz = (rv == 0);
        mn = (rv >= 128);
      end
      for (int r = 0; r < 4; r++) imem[10 + r] = enc(T_OUT, 2'(r), 2'd0, 8'h00);
      reset_core();
      for (int r = 0; r < 4; r++) begin
        wait_out(int'($urandom_range(0, 3)), got8, got_flags, cyc, stable, seen);
        checkOutput("rand_out_seen", seen, 1);
        checkOutput("rand_reg", got8, m[r]);
        checkOutput("rand_flags", got_flags, {mn, mz});
      end
      wait_halt("rand_halted");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
